stream_src_ctrl: RTL and testbench

- Parametrised successor to the two-source (fibonacci/timer) top-level controller.
- Arbitrates NUM_CH data producers into one write port of the cross-domain FIFO wrapper.
- Handles start per channel, pause on FIFO full, stop with drain, and sample counting.
- All outputs are registered; no combinational latches.

---
 rtl/stream_ctrl_pkg.sv | 28 ++
 rtl/stream_src_ctrl_prio_sel.sv | 24 ++
 rtl/stream_src_ctrl.sv | 131 +++++++++++++
 tb/tb_stream_src_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/stream_ctrl_pkg.sv
// rtl/stream_ctrl_pkg.sv - shared state encoding, LED mapping and width helper for stream_src_ctrl
package stream_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    // One-hot LED pattern shown for each controller state
    function automatic logic [3:0] state_led_of(input state_t s);
        logic [3:0] led;
        case (s)
            S_IDLE:  led = 4'b0001;
            S_RUN:   led = 4'b0010;
            S_PAUSE: led = 4'b0100;
            default: led = 4'b1000;
        endcase
        return led;
    endfunction

    // Index width for a channel count; at least one bit so ports never collapse
    function automatic int ch_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_src_ctrl_prio_sel.sv
// rtl/stream_src_ctrl_prio_sel.sv - lowest-index priority encoder used for start arbitration
module prio_sel
    import stream_ctrl_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = ch_w(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan from the top down so the lowest set request is the last one to win
    always_comb begin
        idx = '0;
        any = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/stream_src_ctrl.sv
// rtl/stream_src_ctrl.sv - NUM_CH producer to FIFO write-port controller; optional AUTO_STOP_EN auto-stop at MAX_SAMPLES
module stream_src_ctrl
    import stream_ctrl_pkg::*;
#(
    parameter  int NUM_CH      = 4,
    parameter  int DATA_W      = 16,
    parameter  int CNT_W       = 16,
    parameter  int MAX_SAMPLES = 1000,
    localparam int CH_W        = ch_w(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        start,
    input  logic                     stop,
    input  logic [NUM_CH-1:0]        src_valid,
    input  logic [NUM_CH*DATA_W-1:0] src_data,
    input  logic                     buf_full,
    input  logic                     buf_empty,
    input  logic                     sink_busy,
    output logic [NUM_CH-1:0]        src_en,
    output logic                     wr_en,
    output logic [DATA_W-1:0]        wr_data,
    output logic [CH_W-1:0]          active_ch,
    output logic [3:0]               state_led,
    output logic [CNT_W-1:0]         sample_cnt
);

`ifdef AUTO_STOP_EN
    localparam bit AUTO_STOP = 1'b1;
`else
    localparam bit AUTO_STOP = 1'b0;
`endif
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SAMPLES);

    state_t              state;
    state_t              state_nx;
    logic [CH_W-1:0]     ch_nx;
    logic [NUM_CH-1:0]   start_q;
    logic                stop_q;
    logic [NUM_CH-1:0]   start_edge;
    logic                stop_edge;
    logic [CH_W-1:0]     sel_idx;
    logic                sel_any;
    logic                accept;
    logic                auto_hit;
    logic [CNT_W-1:0]    cnt_inc;

    // History registers start at zero, so a level held through reset reads as an edge
    always_comb begin
        start_edge = start & ~start_q;
        stop_edge  = stop & ~stop_q;
    end

    prio_sel #(.N(NUM_CH)) u_prio_sel (
        .req (start_edge),
        .idx (sel_idx),
        .any (sel_any)
    );

    // Sample acceptance and saturating count; the full flag is checked in the accepting cycle
    always_comb begin
        accept   = (state == S_RUN) && src_valid[active_ch] && !buf_full;
        cnt_inc  = (sample_cnt == '1) ? sample_cnt : sample_cnt + 1'b1;
        auto_hit = AUTO_STOP && accept && (cnt_inc == MAX_CNT);
    end

    // Next-state and next-channel selection; stop beats full/not-full transitions
    always_comb begin
        state_nx = state;
        ch_nx    = active_ch;
        case (state)
            S_IDLE: begin
                if (sel_any) begin
                    state_nx = S_RUN;
                    ch_nx    = sel_idx;
                end
            end
            S_RUN: begin
                if (stop_edge || auto_hit) begin
                    state_nx = S_DRAIN;
                end else if (buf_full) begin
                    state_nx = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (stop_edge) begin
                    state_nx = S_DRAIN;
                end else if (!buf_full) begin
                    state_nx = S_RUN;
                end
            end
            default: begin
                if (buf_empty && !sink_busy) begin
                    state_nx = S_IDLE;
                end
            end
        endcase
    end

    // State register plus registered outputs that follow the next state on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            start_q    <= '0;
            stop_q     <= 1'b0;
            active_ch  <= '0;
            src_en     <= '0;
            state_led  <= 4'b0001;
            wr_en      <= 1'b0;
            wr_data    <= '0;
            sample_cnt <= '0;
        end else begin
            state     <= state_nx;
            start_q   <= start;
            stop_q    <= stop;
            active_ch <= ch_nx;
            state_led <= state_led_of(state_nx);
            src_en    <= (state_nx == S_RUN) ? ({{(NUM_CH-1){1'b0}}, 1'b1} << ch_nx) : '0;
            wr_en     <= accept;
            if (accept) begin
                wr_data <= src_data[active_ch*DATA_W +: DATA_W];
            end
            if (state == S_IDLE && sel_any) begin
                sample_cnt <= '0;
            end else if (accept) begin
                sample_cnt <= cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_stream_src_ctrl.sv
// tb/tb_stream_src_ctrl.sv - self-checking bench for stream_src_ctrl with a behavioural reference model
module tb_stream_src_ctrl;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;
    localparam int MAX_S  = 8;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_CH-1:0]        start;
    logic                     stop;
    logic [NUM_CH-1:0]        src_valid;
    logic [NUM_CH*DATA_W-1:0] src_data;
    logic                     buf_full;
    logic                     buf_empty;
    logic                     sink_busy;
    logic [NUM_CH-1:0]        src_en;
    logic                     wr_en;
    logic [DATA_W-1:0]        wr_data;
    logic [1:0]               active_ch;
    logic [3:0]               state_led;
    logic [CNT_W-1:0]         sample_cnt;

    int checks   = 0;
    int failures = 0;

    // reference model: mode 0 idle, 1 run, 2 pause, 3 drain
    int                m_mode;
    int                m_ch;
    int                m_cnt;
    logic              m_wr;
    logic [DATA_W-1:0] m_data;
    logic [NUM_CH-1:0] m_pstart;
    logic              m_pstop;
    bit                m_auto;

    always #5 clk = ~clk;

    stream_src_ctrl #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W), .MAX_SAMPLES(MAX_S)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .src_valid(src_valid), .src_data(src_data),
        .buf_full(buf_full), .buf_empty(buf_empty), .sink_busy(sink_busy),
        .src_en(src_en), .wr_en(wr_en), .wr_data(wr_data),
        .active_ch(active_ch), .state_led(state_led), .sample_cnt(sample_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_edge();
        logic [NUM_CH-1:0] sedge;
        bit                pedge;
        bit                take;
        bit                done;
        if (rst) begin
            m_mode = 0; m_ch = 0; m_cnt = 0; m_wr = 0; m_data = '0;
            m_pstart = '0; m_pstop = 0;
            return;
        end
        sedge = start & ~m_pstart;
        pedge = stop && !m_pstop;
        m_wr  = 0;
        if (m_mode == 0) begin
            if (sedge != 0) begin
                for (int i = NUM_CH - 1; i >= 0; i--) if (sedge[i]) m_ch = i;
                m_cnt  = 0;
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            take = src_valid[m_ch] && !buf_full;
            if (take) begin
                m_wr   = 1;
                m_data = src_data[m_ch*DATA_W +: DATA_W];
                if (m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
            end
            done = pedge || (m_auto && take && m_cnt == MAX_S);
            m_mode = done ? 3 : (buf_full ? 2 : 1);
        end else if (m_mode == 2) begin
            m_mode = pedge ? 3 : (buf_full ? 2 : 1);
        end else begin
            if (buf_empty && !sink_busy) m_mode = 0;
        end
        m_pstart = start;
        m_pstop  = stop;
    endtask

    task automatic step();
        logic [3:0]        e_led;
        logic [NUM_CH-1:0] e_en;
        model_edge();
        @(posedge clk);
        #1;
        e_led = 4'b0001 << m_mode;
        e_en  = (m_mode == 1) ? (NUM_CH'(1) << m_ch) : '0;
        chk("state_led", state_led, e_led);
        chk("src_en", src_en, e_en);
        chk("wr_en", wr_en, m_wr);
        chk("wr_data", wr_data, m_data);
        chk("active_ch", active_ch, m_ch);
        chk("sample_cnt", sample_cnt, m_cnt);
    endtask

    initial begin
`ifdef AUTO_STOP_EN
        m_auto = 1;
`else
        m_auto = 0;
`endif
        m_mode = 0; m_ch = 0; m_cnt = 0; m_wr = 0; m_data = '0; m_pstart = '0; m_pstop = 0;

        // reset held with start[2] high
        rst = 1; start = 4'b0100; stop = 0; src_valid = '0; src_data = '0;
        buf_full = 0; buf_empty = 1; sink_busy = 0;
        step(); step();
        chk("rst_led", state_led, 4'b0001);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_cnt", sample_cnt, 0);

        // release: held start level counts as an edge
        rst = 0;
        step();
        chk("first_ch", active_ch, 2);
        chk("first_src_en", src_en, 4'b0100);
        src_valid = 4'b0100; src_data = 64'h0005 << 32;
        step();
        chk("first_wr_en", wr_en, 1);
        chk("first_wr_data", wr_data, 16'h0005);
        src_valid = '0;

        // stop then drain straight back to idle
        stop = 1; step(); step();
        chk("idle_cnt_held", sample_cnt, 1);
        chk("idle_led", state_led, 4'b0001);

        // simultaneous starts on 1 and 3: lowest wins; later start[3] edge ignored
        stop = 0; start = '0; step();
        start = 4'b1010; step();
        chk("arb_ch", active_ch, 1);
        start = 4'b0010; step();
        start = 4'b1010; step();
        chk("no_switch_ch", active_ch, 1);

        // pause on full, resume on not-full
        src_valid = 4'b0010; src_data = 64'h0000_0000_1234_0000;
        buf_full = 1; step();
        chk("pause_led", state_led, 4'b0100);
        chk("pause_src_en", src_en, 0);
        step();
        chk("pause_no_wr", wr_en, 0);
        buf_full = 0; step(); step();
        chk("resume_wr", wr_en, 1);

        // stop edge together with full: drain wins, then hold on sink_busy
        buf_full = 1; stop = 1; step();
        chk("stop_over_full", state_led, 4'b1000);
        buf_full = 0; sink_busy = 1; step(); step();
        chk("drain_busy", state_led, 4'b1000);
        sink_busy = 0; step();
        stop = 0; start = '0; src_valid = '0; step();

        // back-to-back samples: auto-stop at MAX_S when enabled, else keep running and saturate
        start = 4'b0001; src_valid = 4'b0001; buf_empty = 0; step();
        for (int i = 0; i < 12; i++) begin
            src_data[15:0] = 16'($urandom);
            step();
        end
`ifdef AUTO_STOP_EN
        chk("auto_led", state_led, 4'b1000);
        chk("auto_cnt", sample_cnt, 8);
`else
        chk("noauto_led", state_led, 4'b0010);
        chk("noauto_cnt", sample_cnt, 12);
        for (int i = 0; i < 8; i++) step();
        chk("sat_cnt", sample_cnt, 15);
`endif

        // reset in the accepting cycle discards the pending write
        buf_empty = 1; rst = 1; step();
        rst = 0; start = '0; step();
        start = 4'b0001; step();
        rst = 1; step();
        chk("midrst_led", state_led, 4'b0001);
        chk("midrst_wr_en", wr_en, 0);
        chk("midrst_cnt", sample_cnt, 0);
        rst = 0;

        // randomized soak
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 7) == 0) start = NUM_CH'($urandom);
            if ($urandom_range(0, 19) == 0) stop = ~stop;
            src_valid = NUM_CH'($urandom);
            src_data  = {$urandom, $urandom};
            buf_full  = ($urandom_range(0, 3) == 0);
            buf_empty = ($urandom_range(0, 2) != 0);
            sink_busy = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
